// File: rtl/dcache_pkg.sv
// Shared types and default sizing for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } dcache_state_t;

  localparam int DEF_LINES  = 16;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data line storage: combinational read port, one synchronous write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  localparam int INDEX_BITS = index_bits(LINES),
  localparam int TAG_W      = ADDR_W - INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Only the valid bits are cleared; a stale tag/data is unreachable until refilled.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller between
// the MEM stage and a word-addressed memory with a held-request/mem_ready handshake.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              ctrl_mem_read,
  input  logic              ctrl_mem_write,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready
);

  localparam int INDEX_BITS = index_bits(LINES);
  localparam int TAG_W      = ADDR_W - INDEX_BITS;

  dcache_state_t state;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_index;
  logic [TAG_W-1:0]      wr_tag;
  logic [DATA_W-1:0]     wr_data;
  logic                  hit;
  logic                  is_store;
  logic                  is_load;

  dcache_array #(
    .LINES (LINES),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .rd_index(address[INDEX_BITS-1:0]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_index(wr_index),
    .wr_tag  (wr_tag),
    .wr_data (wr_data)
  );

  // A simultaneous load and store is handled as a store.
  assign is_store = ctrl_mem_write;
  assign is_load  = ctrl_mem_read && !ctrl_mem_write;
  assign hit      = rd_valid && (rd_tag == address[ADDR_W-1:INDEX_BITS]);

  always_comb begin
    stall     = 1'b0;
    read_data = '0;
    wr_en     = 1'b0;
    wr_index  = address[INDEX_BITS-1:0];
    wr_tag    = address[ADDR_W-1:INDEX_BITS];
    wr_data   = write_data;
    case (state)
      IDLE: begin
        if (is_store) begin
          stall = 1'b1;
          wr_en = hit;
        end else if (is_load) begin
          if (hit) read_data = rd_data;
          else     stall     = 1'b1;
        end
      end
      FILL: begin
        stall = !mem_ready;
        if (mem_ready) begin
          read_data = mem_read_data;
          wr_en     = 1'b1;
          wr_index  = mem_address[INDEX_BITS-1:0];
          wr_tag    = mem_address[ADDR_W-1:INDEX_BITS];
          wr_data   = mem_read_data;
        end
      end
      WRITE: stall = !mem_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_store) begin
            mem_address    <= address;
            mem_write_data <= write_data;
            state          <= WRITE;
          end else if (is_load && !hit) begin
            mem_address <= address;
            state       <= FILL;
          end
        end
        FILL:    if (mem_ready) state <= IDLE;
        WRITE:   if (mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_read  = (state == FILL);
  assign mem_write = (state == WRITE);

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed self-checking bench for data_cache_ctrl with a hand-driven memory side.
module tb_data_cache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        ctrl_mem_read;
  logic        ctrl_mem_write;
  logic [31:0] read_data;
  logic        stall;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  data_cache_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .write_data    (write_data),
    .ctrl_mem_read (ctrl_mem_read),
    .ctrl_mem_write(ctrl_mem_write),
    .read_data     (read_data),
    .stall         (stall),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_read_data (mem_read_data),
    .mem_ready     (mem_ready)
  );

  // Advance one clock and land 1 time unit after the next falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic cpu_idle();
    ctrl_mem_read  = 1'b0;
    ctrl_mem_write = 1'b0;
    mem_ready      = 1'b0;
    mem_read_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    address = '0; write_data = '0;
    cpu_idle();
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("FAIL reset_req got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (mem_address !== 32'h0) begin failures++; $display("FAIL reset_maddr got=%h exp=0", mem_address); end
    checks++; if (mem_write_data !== 32'h0) begin failures++; $display("FAIL reset_mwdata got=%h exp=0", mem_write_data); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
  endtask

  task automatic test_load_miss_hit();
    address = 32'd5; ctrl_mem_read = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL miss_req_stall got=%0b exp=1", stall); end
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL miss_req_mread got=%0b exp=0", mem_read); end
    step();
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'd5) begin failures++; $display("FAIL fill1 mread=%0b maddr=%h exp 1/5", mem_read, mem_address); end
    checks++; if (stall !== 1'b1 || read_data !== 32'h0) begin failures++; $display("FAIL fill1_stall stall=%0b rdata=%h exp 1/0", stall, read_data); end
    step();
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'd5 || stall !== 1'b1) begin failures++; $display("FAIL fill2 mread=%0b maddr=%h stall=%0b", mem_read, mem_address, stall); end
    step();
    mem_read_data = 32'hDEADBEEF; mem_ready = 1'b1; #1;
    checks++; if (read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL fill_bypass got=%h exp=deadbeef", read_data); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fill_done_stall got=%0b exp=0", stall); end
    step();
    mem_ready = 1'b0; mem_read_data = 32'h0; #1;
    checks++; if (stall !== 1'b0 || mem_read !== 1'b0) begin failures++; $display("FAIL hit_stall stall=%0b mread=%0b exp 0/0", stall, mem_read); end
    checks++; if (read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL hit_data got=%h exp=deadbeef", read_data); end
    step();
    checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL hit_no_fill got=%0b exp=0", mem_read); end
    cpu_idle(); step();
  endtask

  task automatic test_conflict();
    address = 32'd21; ctrl_mem_read = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL conflict_miss got=%0b exp=1", stall); end
    step();
    mem_read_data = 32'hAAAA0021; mem_ready = 1'b1; #1;
    checks++; if (mem_address !== 32'd21 || read_data !== 32'hAAAA0021 || stall !== 1'b0) begin failures++; $display("FAIL conflict_fill maddr=%h rdata=%h stall=%0b", mem_address, read_data, stall); end
    step();
    mem_ready = 1'b0; #1;
    checks++; if (stall !== 1'b0 || read_data !== 32'hAAAA0021) begin failures++; $display("FAIL conflict_hit stall=%0b rdata=%h", stall, read_data); end
    address = 32'd5; #1;
    checks++; if (stall !== 1'b1 || read_data !== 32'h0) begin failures++; $display("FAIL evicted_miss stall=%0b rdata=%h exp 1/0", stall, read_data); end
    step();
    mem_read_data = 32'hDEADBEEF; mem_ready = 1'b1;
    step();
    cpu_idle(); step();
  endtask

  task automatic test_store_hit();
    address = 32'd5; write_data = 32'h12345678; ctrl_mem_write = 1'b1; #1;
    checks++; if (stall !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL store_req stall=%0b mwrite=%0b exp 1/0", stall, mem_write); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'd5 || mem_write_data !== 32'h12345678 || stall !== 1'b1) begin
        failures++; $display("FAIL store_hold%0d mw=%0b mr=%0b ma=%h md=%h stall=%0b", i, mem_write, mem_read, mem_address, mem_write_data, stall);
      end
    end
    mem_ready = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_done got=%0b exp=0", stall); end
    step();
    mem_ready = 1'b0; ctrl_mem_write = 1'b0; ctrl_mem_read = 1'b1; #1;
    checks++; if (stall !== 1'b0 || read_data !== 32'h12345678) begin failures++; $display("FAIL store_hit_load stall=%0b rdata=%h exp 0/12345678", stall, read_data); end
    cpu_idle(); step();
  endtask

  task automatic test_store_miss();
    address = 32'd9; write_data = 32'h00000099; ctrl_mem_write = 1'b1;
    step();
    checks++; if (mem_write !== 1'b1 || mem_address !== 32'd9 || mem_write_data !== 32'h99) begin failures++; $display("FAIL nwa_write mw=%0b ma=%h md=%h", mem_write, mem_address, mem_write_data); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; ctrl_mem_write = 1'b0; ctrl_mem_read = 1'b1; #1;
    checks++; if (mem_write !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL nwa_load_miss mw=%0b stall=%0b exp 0/1", mem_write, stall); end
    step();
    mem_ready = 1'b1; mem_read_data = 32'h00000999;
    step();
    cpu_idle(); step();
  endtask

  task automatic test_reset_fill();
    address = 32'd7; ctrl_mem_read = 1'b1;
    step(); step();
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL abort_in_fill got=%0b exp=1", mem_read); end
    reset = 1'b1; ctrl_mem_read = 1'b0;
    step();
    reset = 1'b0; #1;
    checks++; if (mem_read !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL abort_idle mread=%0b stall=%0b exp 0/0", mem_read, stall); end
    ctrl_mem_read = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL abort_reload_miss got=%0b exp=1", stall); end
    step();
    mem_ready = 1'b1; mem_read_data = 32'h77;
    step();
    cpu_idle(); step();
  endtask

  task automatic test_both_asserted();
    address = 32'd3; write_data = 32'h55; ctrl_mem_read = 1'b1; ctrl_mem_write = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL both_req stall=%0b exp=1", stall); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_write_data !== 32'h55) begin failures++; $display("FAIL both_write%0d mw=%0b mr=%0b md=%h", i, mem_write, mem_read, mem_write_data); end
    end
    mem_ready = 1'b1;
    step();
    cpu_idle(); #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL both_after mr=%0b mw=%0b exp 0/0", mem_read, mem_write); end
    mem_ready = 1'b1;
    step();
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL idle_ready_ignored mr=%0b mw=%0b stall=%0b", mem_read, mem_write, stall); end
    cpu_idle(); step();
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_load_miss_hit();
    test_conflict();
    test_store_hit();
    test_store_miss();
    test_reset_fill();
    test_both_asserted();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
# data_cache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller between the pipeline MEM stage and the word-addressed data memory. It answers MEM-stage loads and stores and acts as initiator toward the data memory over a held-request / `mem_ready` handshake. It drives `stall` to freeze the pipeline while a memory transaction is outstanding.

## Interface
- `LINES`, 16: number of cache lines; power of two, at least 2. `INDEX_BITS = log2(LINES)`.
- `ADDR_W`, 32: word-address width.
- `DATA_W`, 32: data word width.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in ADDR_W: CPU word address.
- `write_data` in DATA_W: CPU store data.
- `ctrl_mem_read` in 1: CPU load request.
- `ctrl_mem_write` in 1: CPU store request.
- `read_data` out DATA_W: load result; combinational.
- `stall` out 1: pipeline hold; combinational.
- `mem_address` out ADDR_W: memory word address.
- `mem_write_data` out DATA_W: memory store data.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `mem_read_data` in DATA_W: memory read result; valid when `mem_ready`=1.
- `mem_ready` in 1: memory completion strobe.

## Operation
- Line contents: valid bit, tag `address[ADDR_W-1:INDEX_BITS]`, one data word. Index = `address[INDEX_BITS-1:0]`.
- Hit: selected line is valid and its tag matches.
- FSM states: IDLE, FILL, WRITE.
- IDLE, load hit:
  - `read_data` = line data; `stall`=0.
  - Stay in IDLE.
- IDLE, load miss:
  - `stall`=1.
  - Latch address into `mem_address`.
  - Next state FILL.
- IDLE, store (hit or miss):
  - `stall`=1.
  - Latch address and data into `mem_address` / `mem_write_data`.
  - On hit, update line data on this edge. On miss, the line is unchanged (no allocate).
  - Next state WRITE.
- Load and store both asserted: treated as a store.
- FILL:
  - `mem_read`=1; `stall`=1 while `mem_ready`=0.
  - When `mem_ready`=1: write line (valid=1, tag, `mem_read_data`), drive `read_data` = `mem_read_data` (bypass), `stall`=0, next state IDLE.
- WRITE:
  - `mem_write`=1; `stall`=1 while `mem_ready`=0.
  - When `mem_ready`=1: `stall`=0, next state IDLE.
- `mem_read` / `mem_write` are decoded from the state only. They are never asserted in IDLE and never both at once.
- `mem_address` and `mem_write_data` are held stable throughout FILL and WRITE.
- `read_data` is 0 whenever it is not carrying a hit or bypass value.
- `mem_ready` while in IDLE is ignored.

## Timing
- Reset values (register and derived outputs):
  - State IDLE; all valid bits 0.
  - `mem_address` 0, `mem_write_data` 0.
  - `mem_read` 0, `mem_write` 0, `stall` 0.
  - `read_data` 0.
- Reset asserted mid-FILL or mid-WRITE aborts the transaction: next edge returns to IDLE, and no line is written.
- Load hit: 0 wait cycles.
- Load miss: request cycle plus N FILL cycles. Minimum 2 cycles total, when `mem_ready`=1 in the first FILL cycle.
- Store: request cycle plus N WRITE cycles. Minimum 2 cycles.
- The CPU holds `address`, `write_data` and the ctrl signals while `stall`=1. The controller samples the new request only when the FSM is back in IDLE.
- Consecutive misses: the cycle after FILL completes is IDLE, and a new request is evaluated there.

## Structure
- Package `dcache_pkg`:
  - State enum `dcache_state_t` {IDLE, FILL, WRITE}.
  - Default `LINES` / `ADDR_W` / `DATA_W`.
  - `INDEX_BITS` derivation function.
- Sub-module `dcache_array`:
  - Valid/tag/data storage with a combinational read port.
  - One synchronous write port.
  - Synchronous clear of valid bits on `reset`.
- The controller holds only the FSM, the address/data latches and the output decode.

## Test plan
- Load to address 5 after reset → miss: `stall`=1, `mem_read` rises next cycle with `mem_address`=5. Memory returns 0xDEADBEEF with `mem_ready` after 3 cycles → `read_data`=0xDEADBEEF with `stall`=0 in that same cycle. A repeat load of 5 → hit, `stall`=0, no `mem_read`.
- Address 5 cached, then load address 21 (same index, different tag, LINES=16) → miss and refill. A subsequent load of 5 misses again.
- Store 0x12345678 to cached address 5 → `mem_write`=1 with address 5 and data 0x12345678 held until `mem_ready`. A following load of 5 hits with 0x12345678.
- Store to uncached address 9 → memory write only. A following load of 9 misses (no allocate).
- `reset` asserted in the second FILL cycle → next cycle IDLE, `mem_read`=0, `stall`=0. A load of that address then misses.
- `ctrl_mem_read` and `ctrl_mem_write` both asserted → the store path is taken (`mem_write`=1, `mem_read` never asserted).
